// File: rtl/vdp_blend_layer_select.sv
// Per-pixel layer arbiter feeding the VDP alpha blender: picks source/dest operands.
// Optional blend statistics output enabled by defining VDP_LAYER_SELECT_STATS_EN.
module vdp_blend_layer_select #(
  parameter int LAYERS     = 5,
  parameter int INDEX_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pixel_valid,
  input  logic [LAYERS*16-1:0]  layer_colors,
  input  logic [15:0]           backdrop_color,
  input  logic [LAYERS-1:0]     cfg_layer_enable,
  input  logic [LAYERS-1:0]     cfg_blend_mask,
  input  logic                  cfg_update,
  input  logic                  line_start,
  output logic [15:0]           source_color,
  output logic                  source_layer_enabled,
  output logic [15:0]           dest_color,
  output logic [INDEX_BITS-1:0] source_index,
  output logic [INDEX_BITS-1:0] dest_index,
  output logic                  out_valid
`ifdef VDP_LAYER_SELECT_STATS_EN
  ,
  output logic [15:0]           blend_count
`endif
);

  localparam logic [INDEX_BITS-1:0] NONE_IDX = INDEX_BITS'(LAYERS);

  // Config double buffer
  logic [LAYERS-1:0] pend_enable_reg, pend_blend_reg;
  logic [LAYERS-1:0] act_enable_reg, act_blend_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_enable_reg <= '0;
      pend_blend_reg  <= '0;
      act_enable_reg  <= '0;
      act_blend_reg   <= '0;
    end else begin
      if (cfg_update) begin
        pend_enable_reg <= cfg_layer_enable;
        pend_blend_reg  <= cfg_blend_mask;
      end
      // A simultaneous update bypasses pending so the new line sees fresh values.
      if (line_start) begin
        act_enable_reg <= cfg_update ? cfg_layer_enable : pend_enable_reg;
        act_blend_reg  <= cfg_update ? cfg_blend_mask   : pend_blend_reg;
      end
    end
  end

  // Stage 1: capture pixel plus a snapshot of the config it was issued under
  logic [LAYERS-1:0]    visible_next;
  logic [LAYERS*16-1:0] s1_colors_reg;
  logic [11:0]          s1_backdrop_reg;
  logic [LAYERS-1:0]    s1_visible_reg;
  logic [LAYERS-1:0]    s1_blend_reg;
  logic                 s1_valid_reg;
  logic [15:0]          s1_color_arr [LAYERS];
  logic                 unused_backdrop_alpha;

  assign unused_backdrop_alpha = ^backdrop_color[15:12];

  genvar gi;
  generate
    for (gi = 0; gi < LAYERS; gi++) begin : g_layer
      assign visible_next[gi] = (layer_colors[16*gi+12 +: 4] != 4'h0) && act_enable_reg[gi];
      assign s1_color_arr[gi] = s1_colors_reg[16*gi +: 16];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_colors_reg   <= '0;
      s1_backdrop_reg <= '0;
      s1_visible_reg  <= '0;
      s1_blend_reg    <= '0;
      s1_valid_reg    <= 1'b0;
    end else begin
      s1_valid_reg <= pixel_valid;
      if (pixel_valid) begin
        s1_colors_reg   <= layer_colors;
        s1_backdrop_reg <= backdrop_color[11:0];
        s1_visible_reg  <= visible_next;
        s1_blend_reg    <= act_blend_reg;
      end
    end
  end

  // Stage 2 selection: top visible layer T and next visible layer U below it
  logic                  top_found, under_found, top_blend;
  logic [INDEX_BITS-1:0] top_idx, under_idx;
  logic [15:0]           top_color, under_color, backdrop_full;
  logic [15:0]           source_color_next, dest_color_next;
  logic                  source_en_next;
  logic [INDEX_BITS-1:0] source_index_next, dest_index_next;

  assign backdrop_full = {4'hF, s1_backdrop_reg};

  always_comb begin
    top_found   = 1'b0;
    under_found = 1'b0;
    top_blend   = 1'b0;
    top_idx     = NONE_IDX;
    under_idx   = NONE_IDX;
    top_color   = 16'h0000;
    under_color = 16'h0000;
    for (int i = 0; i < LAYERS; i++) begin
      if (s1_visible_reg[i]) begin
        if (!top_found) begin
          top_found = 1'b1;
          top_idx   = INDEX_BITS'(i);
          top_color = s1_color_arr[i];
          top_blend = s1_blend_reg[i];
        end else if (!under_found) begin
          under_found = 1'b1;
          under_idx   = INDEX_BITS'(i);
          under_color = s1_color_arr[i];
        end
      end
    end
  end

  always_comb begin
    source_color_next = 16'h0000;
    source_en_next    = 1'b0;
    source_index_next = NONE_IDX;
    dest_color_next   = backdrop_full;
    dest_index_next   = NONE_IDX;
    if (top_found && !top_blend) begin
      dest_color_next = top_color;
      dest_index_next = top_idx;
    end else if (top_found) begin
      source_color_next = top_color;
      source_en_next    = 1'b1;
      source_index_next = top_idx;
      // Only one blend level: U is the dest even if U is itself blend-enabled.
      if (under_found) begin
        dest_color_next = under_color;
        dest_index_next = under_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      source_color         <= '0;
      source_layer_enabled <= 1'b0;
      dest_color           <= '0;
      source_index         <= NONE_IDX;
      dest_index           <= NONE_IDX;
      out_valid            <= 1'b0;
    end else begin
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        source_color         <= source_color_next;
        source_layer_enabled <= source_en_next;
        dest_color           <= dest_color_next;
        source_index         <= source_index_next;
        dest_index           <= dest_index_next;
      end
    end
  end

`ifdef VDP_LAYER_SELECT_STATS_EN
  logic [15:0] run_count_reg;
  logic        blend_hit;

  assign blend_hit = s1_valid_reg && source_en_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_count_reg <= '0;
      blend_count   <= '0;
    end else if (line_start) begin
      blend_count   <= run_count_reg;
      run_count_reg <= blend_hit ? 16'd1 : 16'd0;
    end else if (blend_hit && run_count_reg != 16'hFFFF) begin
      run_count_reg <= run_count_reg + 16'd1;
    end
  end
`endif

endmodule
